// File: rtl/usb_rx_pkg.sv
// usb_rx_pkg: shared state encoding and constants for the USB receive control unit
package usb_rx_pkg;
  typedef enum logic [3:0] {
    IDLE, RCV_SYNC, CHK_SYNC, RCV_PID, CHK_PID,
    RCV_DATA, STORE, EOP_WAIT, ERR_WAIT, EIDLE
  } rcu_state_t;
  localparam logic [7:0] SYNC_BYTE = 8'h80;
  localparam int DEFAULT_MAX_BYTES = 64;
  // A PID byte carries its nibble and the nibble's complement
  function automatic logic pid_ok(input logic [7:0] b);
    return b[7:4] == ~b[3:0];
  endfunction
endpackage

// File: rtl/usb_rx_rcu_if.sv
// usb_rx_rcu_if: bit-timer/edge-detector strobes in, FIFO and status outputs back
interface usb_rx_rcu_if;
  logic       d_edge;
  logic       eop;
  logic       shift_enable;
  logic       byte_received;
  logic [7:0] rcv_data;
  logic       rcving;
  logic       w_enable;
  logic       r_error;
  logic [3:0] pid;
  logic       pkt_done;
  logic [6:0] byte_count;
  modport master (
    output d_edge, eop, shift_enable, byte_received, rcv_data,
    input  rcving, w_enable, r_error, pid, pkt_done, byte_count
  );
  modport slave (
    input  d_edge, eop, shift_enable, byte_received, rcv_data,
    output rcving, w_enable, r_error, pid, pkt_done, byte_count
  );
endinterface

// File: rtl/flex_counter.sv
// flex_counter: clearable up-counter that wraps to 1 after reaching rollover_val
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out
);
  always_ff @(posedge clk or posedge rst)
    if (rst) count_out <= '0;
    else if (clear) count_out <= '0;
    else if (count_enable) count_out <= count_out == rollover_val ? NUM_CNT_BITS'(1) : count_out + NUM_CNT_BITS'(1);
endmodule

// File: rtl/usb_rx_rcu.sv
// usb_rx_rcu: sequences SYNC/PID/data byte checks of a USB packet and raises FIFO writes and status
module usb_rx_rcu
  import usb_rx_pkg::*;
#(
  parameter int MAX_BYTES = DEFAULT_MAX_BYTES
) (
  input logic        clk,
  input logic        rst,
  usb_rx_rcu_if.slave bus
);
  localparam logic [6:0] MAX_CNT = 7'(MAX_BYTES);
  rcu_state_t state, next;
  logic [2:0] bit_cnt;
  logic [3:0] pid_q;
  logic [6:0] cnt;
  logic       done_q, eop_shift, to_sync, full, wen;
  assign eop_shift = bus.eop && bus.shift_enable;
  assign to_sync   = (state == IDLE || state == EIDLE) && bus.d_edge;
  assign full      = cnt == MAX_CNT;
  assign wen       = state == STORE && !full;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      pid_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state   <= next;
      bit_cnt <= (to_sync || bus.byte_received) ? 3'd0 : bit_cnt + 3'(bus.shift_enable);
      pid_q   <= to_sync ? 4'h0 : (state == CHK_PID && next == RCV_DATA) ? bus.rcv_data[3:0] : pid_q;
      done_q  <= state == EOP_WAIT && bus.d_edge;
    end
  always_comb begin
    next = state;
    case (state)
      IDLE:     next = bus.d_edge ? RCV_SYNC : IDLE;
      RCV_SYNC: next = eop_shift ? ERR_WAIT : bus.byte_received ? CHK_SYNC : RCV_SYNC;
      CHK_SYNC: next = (!eop_shift && bus.rcv_data == SYNC_BYTE) ? RCV_PID : ERR_WAIT;
      RCV_PID:  next = eop_shift ? ERR_WAIT : bus.byte_received ? CHK_PID : RCV_PID;
      CHK_PID:  next = (!eop_shift && pid_ok(bus.rcv_data)) ? RCV_DATA : ERR_WAIT;
      RCV_DATA: next = bus.byte_received ? STORE : !eop_shift ? RCV_DATA : bit_cnt == 3'd0 ? EOP_WAIT : ERR_WAIT;
      STORE:    next = full ? ERR_WAIT : RCV_DATA;
      EOP_WAIT: next = bus.d_edge ? IDLE : EOP_WAIT;
      ERR_WAIT: next = (bus.d_edge && !bus.eop) ? EIDLE : ERR_WAIT;
      EIDLE:    next = bus.d_edge ? RCV_SYNC : EIDLE;
      default:  next = IDLE;
    endcase
  end
  // Counter only advances on a real write, so it holds at MAX_BYTES instead of wrapping
  flex_counter #(.NUM_CNT_BITS(7)) u_cnt (
    .clk(clk), .rst(rst), .clear(to_sync), .count_enable(wen),
    .rollover_val(MAX_CNT), .count_out(cnt)
  );
  assign bus.rcving     = state inside {RCV_SYNC, CHK_SYNC, RCV_PID, CHK_PID, RCV_DATA, STORE};
  assign bus.w_enable   = wen;
  assign bus.r_error    = state == ERR_WAIT || state == EIDLE;
  assign bus.pid        = pid_q;
  assign bus.pkt_done   = done_q;
  assign bus.byte_count = cnt;
endmodule

// File: tb/tb_usb_rx_rcu.sv
// tb_usb_rx_rcu: scoreboard bench; a packet-level model queues expected writes and packet outcomes
module tb_usb_rx_rcu;
  localparam int MAXB = 64;
  localparam int WR = 0, DONE = 1, ERR = 2;
  typedef struct {int kind; logic [7:0] data; logic [3:0] pid; int cnt;} ev_t;
  logic clk = 0, rst = 1, prev_err = 0;
  always #5 clk = ~clk;
  usb_rx_rcu_if bus();
  usb_rx_rcu #(.MAX_BYTES(MAXB)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  ev_t exp_q[$];
  int compared = 0, mismatched = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic pop_ev(input int kind, input string nm, output ev_t e, output bit ok);
    ok = 0;
    e = '{default: 0};
    chk({nm, " expected"}, exp_q.size() > 0, 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({nm, " kind"}, e.kind, kind);
      ok = e.kind == kind;
    end
  endtask

  always @(negedge clk) begin : mon
    ev_t e;
    bit ok;
    if (!rst) begin
      if (bus.w_enable) begin
        pop_ev(WR, "wr", e, ok);
        if (ok) begin
          chk("wr data", bus.rcv_data, e.data);
          chk("wr count", bus.byte_count, e.cnt);
        end
      end
      if (bus.pkt_done) begin
        pop_ev(DONE, "done", e, ok);
        if (ok) begin
          chk("done pid", bus.pid, e.pid);
          chk("done count", bus.byte_count, e.cnt);
          chk("done r_error", bus.r_error, 0);
        end
      end
      if (bus.r_error && !prev_err) begin
        pop_ev(ERR, "err", e, ok);
        if (ok) begin
          chk("err pid", bus.pid, e.pid);
          chk("err count", bus.byte_count, e.cnt);
          chk("err rcving", bus.rcving, 0);
          chk("err w_enable", bus.w_enable, 0);
        end
      end
    end
    prev_err <= bus.r_error;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_edge();
    bus.d_edge = 1;
    cyc(1);
    bus.d_edge = 0;
  endtask

  task automatic shift(input bit e);
    cyc($urandom_range(1, 3));
    bus.eop = e;
    bus.shift_enable = 1;
    cyc(1);
    bus.shift_enable = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) shift(0);
    bus.rcv_data = b;
    bus.byte_received = 1;
    cyc(1);
    bus.byte_received = 0;
  endtask

  // Expected outcome of a whole packet, decided from the packet's contents alone
  task automatic model(input logic [7:0] sync, input logic [7:0] pb, input logic [7:0] data[$], input int eop_bits);
    if (sync != 8'h80 || (pb[7:4] ^ pb[3:0]) != 4'hF) begin
      exp_q.push_back('{kind: ERR, data: 0, pid: 0, cnt: 0});
      return;
    end
    foreach (data[i]) begin
      if (i == MAXB) begin
        exp_q.push_back('{kind: ERR, data: 0, pid: pb[3:0], cnt: MAXB});
        return;
      end
      exp_q.push_back('{kind: WR, data: data[i], pid: 0, cnt: i});
    end
    exp_q.push_back('{kind: eop_bits == 0 ? DONE : ERR, data: 0, pid: pb[3:0], cnt: data.size()});
  endtask

  task automatic send_pkt(input logic [7:0] sync, input logic [7:0] pb, input logic [7:0] data[$], input int eop_bits);
    model(sync, pb, data, eop_bits);
    pulse_edge();
    cyc(2);
    send_byte(sync);
    send_byte(pb);
    foreach (data[i]) send_byte(data[i]);
    for (int i = 0; i < eop_bits; i++) shift(0);
    shift(1);
    cyc(2);
    bus.eop = 0;
    cyc(2);
    pulse_edge();
    cyc(4);
    chk("drain", exp_q.size(), 0);
  endtask

  initial begin
    logic [7:0] q[$];
    logic [3:0] nib;
    bus.d_edge = 0;
    bus.eop = 0;
    bus.shift_enable = 0;
    bus.byte_received = 0;
    bus.rcv_data = 0;
    cyc(3);
    chk("rst rcving", bus.rcving, 0);
    chk("rst w_enable", bus.w_enable, 0);
    chk("rst r_error", bus.r_error, 0);
    chk("rst pid", bus.pid, 0);
    chk("rst pkt_done", bus.pkt_done, 0);
    chk("rst byte_count", bus.byte_count, 0);
    rst = 0;
    cyc(2);
    q = '{8'h11, 8'h22};
    send_pkt(8'h80, 8'hA5, q, 0);
    chk("idle pid", bus.pid, 4'h5);
    chk("idle count", bus.byte_count, 2);
    q = '{8'h33};
    send_pkt(8'h81, 8'hA5, q, 0);
    q = '{8'h44};
    send_pkt(8'h80, 8'hA4, q, 0);
    q = '{8'h55};
    send_pkt(8'h80, 8'hA5, q, 3);
    q = {};
    for (int i = 0; i < 65; i++) q.push_back(8'($urandom));
    send_pkt(8'h80, 8'h3C, q, 0);
    chk("ovf count held", bus.byte_count, MAXB);
    chk("ovf r_error", bus.r_error, 1);
    // Reset in the middle of a data byte
    exp_q.push_back('{kind: WR, data: 8'h11, pid: 0, cnt: 0});
    exp_q.push_back('{kind: WR, data: 8'h22, pid: 0, cnt: 1});
    pulse_edge();
    cyc(2);
    send_byte(8'h80);
    send_byte(8'hB4);
    send_byte(8'h11);
    send_byte(8'h22);
    for (int i = 0; i < 3; i++) shift(0);
    chk("pre-rst rcving", bus.rcving, 1);
    rst = 1;
    #1;
    chk("mid rst rcving", bus.rcving, 0);
    chk("mid rst w_enable", bus.w_enable, 0);
    chk("mid rst r_error", bus.r_error, 0);
    chk("mid rst pid", bus.pid, 0);
    chk("mid rst pkt_done", bus.pkt_done, 0);
    chk("mid rst count", bus.byte_count, 0);
    cyc(2);
    rst = 0;
    cyc(3);
    chk("rst drain", exp_q.size(), 0);
    q = '{8'hDE, 8'hAD, 8'hBE};
    send_pkt(8'h80, 8'h96, q, 0);
    for (int p = 0; p < 20; p++) begin
      logic [7:0] sync, pb;
      int eb;
      q = {};
      nib = 4'($urandom);
      sync = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h80;
      pb = ($urandom_range(0, 7) == 0) ? 8'($urandom) : {~nib, nib};
      for (int i = 0; i < int'($urandom_range(0, 6)); i++) q.push_back(8'($urandom));
      eb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 7)) : 0;
      send_pkt(sync, pb, q, eb);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/usb_rx_rcu.md
USB_RX_RCU -- requirements
Module: usb_rx_rcu

Interface
REQ-001 The module SHALL have parameter MAX_BYTES, default 64, giving the maximum number of data bytes per packet, excluding SYNC and PID.
REQ-002 The module SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-004 The module SHALL have port d_edge, input, 1 bit: single-cycle pulse on a D+/D- transition from the edge detector.
REQ-005 The module SHALL have port eop, input, 1 bit: end-of-packet line state (SE0), level.
REQ-006 The module SHALL have port shift_enable, input, 1 bit: single-cycle bit-sample strobe from the bit timer.
REQ-007 The module SHALL have port byte_received, input, 1 bit: single-cycle strobe from the bit timer after 8 shifts.
REQ-008 The module SHALL have port rcv_data, input, 8 bits: shift-register contents, valid in the cycle byte_received is high.
REQ-009 The module SHALL have port rcving, output, 1 bit: packet reception in progress; it drives the bit timer's enable.
REQ-010 The module SHALL have port w_enable, output, 1 bit: single-cycle write strobe to the rx FIFO.
REQ-011 The module SHALL have port r_error, output, 1 bit: sticky packet error flag.
REQ-012 The module SHALL have port pid, output, 4 bits: latched packet ID nibble.
REQ-013 The module SHALL have port pkt_done, output, 1 bit: single-cycle pulse on a good packet end.
REQ-014 The module SHALL have port byte_count, output, 7 bits: number of data bytes written in the current packet.

Function
REQ-015 The FSM SHALL have states IDLE, RCV_SYNC, CHK_SYNC, RCV_PID, CHK_PID, RCV_DATA, STORE, EOP_WAIT, ERR_WAIT and EIDLE.
REQ-016 In IDLE, a d_edge pulse SHALL cause a transition to RCV_SYNC and SHALL clear r_error, pid and byte_count.
REQ-017 rcving SHALL be 1 in RCV_SYNC through STORE, and 0 in IDLE, EOP_WAIT, ERR_WAIT and EIDLE.
REQ-018 An internal 3-bit bit counter SHALL increment on shift_enable, clear on byte_received (byte_received wins if both strobes occur together), and clear on entry to RCV_SYNC.
REQ-019 In RCV_SYNC, byte_received SHALL cause a transition to CHK_SYNC.
REQ-020 In CHK_SYNC (one cycle), rcv_data == 8'h80 SHALL cause a transition to RCV_PID; any other value SHALL cause a transition to ERR_WAIT.
REQ-021 In RCV_PID, byte_received SHALL cause a transition to CHK_PID.
REQ-022 In CHK_PID, if rcv_data[7:4] == ~rcv_data[3:0], the module SHALL latch pid <= rcv_data[3:0] and go to RCV_DATA; otherwise it SHALL go to ERR_WAIT.
REQ-023 In RCV_DATA, byte_received SHALL cause a transition to STORE.
REQ-024 In STORE (one cycle), w_enable SHALL be 1 and byte_count SHALL increment, then the FSM SHALL return to RCV_DATA.
REQ-025 If byte_count == MAX_BYTES on entry to STORE, the module SHALL suppress w_enable and go to ERR_WAIT (overflow).
REQ-026 In RCV_DATA, eop && shift_enable with the bit counter == 0 SHALL cause a transition to EOP_WAIT; with the bit counter != 0, it SHALL cause a transition to ERR_WAIT.
REQ-027 eop && shift_enable in RCV_SYNC, CHK_SYNC, RCV_PID or CHK_PID SHALL cause a transition to ERR_WAIT.
REQ-028 In EOP_WAIT, a d_edge pulse SHALL cause a transition to IDLE and SHALL pulse pkt_done for exactly 1 cycle.
REQ-029 In ERR_WAIT, r_error SHALL be 1, and eop low following a d_edge pulse SHALL cause a transition to EIDLE.
REQ-030 In EIDLE, r_error SHALL remain 1, and a d_edge pulse SHALL cause a transition to RCV_SYNC, clearing r_error.
REQ-031 byte_count SHALL saturate at MAX_BYTES and SHALL never wrap.
REQ-032 All outputs SHALL be registered or decoded from the state register only, with no combinational path from inputs to outputs.

Reset
REQ-033 When rst is asserted, the module SHALL set state = IDLE, rcving = 0, w_enable = 0, r_error = 0, pid = 4'h0, pkt_done = 0, byte_count = 0 and bit counter = 0.
REQ-034 When rst is asserted mid-packet, the module SHALL abandon the packet immediately, with no w_enable and no pkt_done.

Structure
REQ-035 Package usb_rx_pkg SHALL hold the rcu_state_t enum, SYNC_BYTE = 8'h80 and DEFAULT_MAX_BYTES = 64.
REQ-036 The byte counter SHALL be implemented as one flex_counter instance (7 bits, rollover_val = MAX_BYTES), with saturation handled by the FSM.

Verification
REQ-037 The bench SHALL drive d_edge, SYNC 0x80, PID 0xA5, data 0x11 and 0x22, then eop on the bit-0 shift_enable, then d_edge, and check: 2 w_enable pulses, pid = 5, byte_count = 2, 1 pkt_done pulse, r_error = 0.
REQ-038 The bench SHALL drive SYNC 0x81 and check: ERR_WAIT, r_error = 1, rcving = 0, no w_enable.
REQ-039 The bench SHALL drive PID 0xA4 and check: r_error = 1 and pid unchanged at 0.
REQ-040 The bench SHALL drive eop after 3 bits of a data byte and check: r_error = 1 and no pkt_done.
REQ-041 The bench SHALL send 65 data bytes with MAX_BYTES = 64 and check: 64 w_enable pulses, then r_error = 1, with byte_count held at 64.
REQ-042 The bench SHALL assert rst during RCV_DATA and check: all outputs return to their reset values, then a subsequent good packet is received correctly.
